// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states, counter width.
// Divide support is compiled in only when MDU_DIV_EN is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } mdu_op_e;

  // Holds cycle counts up to 15.
  localparam int unsigned CntW = 4;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } mdu_state_e;
`else
  typedef enum logic [1:0] {
    StIdle,
    StMul
  } mdu_state_e;
`endif

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

  // Without MDU_DIV_EN, DIV/DIVU decode as nothing at all.
  function automatic logic is_div_op(input logic [2:0] op);
`ifdef MDU_DIV_EN
    return (op == OpDiv) || (op == OpDivu);
`else
    return 1'b0 & (op == OpDiv);
`endif
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generation for multiply and (optionally) divide.
// Divider is present only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic        sgn_mul;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  // One shared 64-bit multiplier; sign extension selects MULT vs MULTU.
  always_comb begin
    sgn_mul = (op_i == OpMult);
    mul_a   = {{32{sgn_mul & a_i[31]}}, a_i};
    mul_b   = {{32{sgn_mul & b_i[31]}}, b_i};
    prod    = mul_a * mul_b;
  end

`ifdef MDU_DIV_EN
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed divide via magnitudes; 0x80000000/-1 wraps naturally to 0x80000000 rem 0.
  always_comb begin
    neg_a = (op_i == OpDiv) & a_i[31];
    neg_b = (op_i == OpDiv) & b_i[31];
    mag_a = neg_a ? (32'd0 - a_i) : a_i;
    mag_b = neg_b ? (32'd0 - b_i) : b_i;
    // Keep the divider X-free on b=0; the result is discarded via wr_o.
    den   = (b_i == 32'd0) ? 32'd1 : mag_b;
    uq    = mag_a / den;
    ur    = mag_a % den;
    quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem   = neg_a ? (32'd0 - ur) : ur;
  end

  // Result select: divide overrides the product.
  always_comb begin
    hi_o = prod[63:32];
    lo_o = prod[31:0];
    wr_o = 1'b1;
    if (is_div_op(op_i)) begin
      hi_o = rem;
      lo_o = quo;
      wr_o = (b_i != 32'd0);
    end
  end
`else
  // Result select: multiply only.
  always_comb begin
    hi_o = prod[63:32];
    lo_o = prod[31:0];
    wr_o = 1'b1;
  end
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: accept logic, busy FSM with cycle counter, HI/LO registers
// and pipeline stall generation. Divide support requires MDU_DIV_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("MUL_CYCLES out of range 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("DIV_CYCLES out of range 1..15");
  end

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  logic            is_mul;
  logic            is_div;
  logic            req;
  logic [31:0]     ar_hi;
  logic [31:0]     ar_lo;
  logic            ar_wr;

  mdu_arith u_arith (
    .op_i (op),
    .a_i  (a),
    .b_i  (b),
    .hi_o (ar_hi),
    .lo_o (ar_lo),
    .wr_o (ar_wr)
  );

  // Decode and unconditioned request (state gating happens in the FSM).
  always_comb begin
    is_mul = is_mul_op(op);
    is_div = is_div_op(op);
    req    = start & ~flush;
  end

  // Stall covers the issue cycle too, so a back-to-back HI/LO consumer waits.
  always_comb begin
    md_stall = md_use & (busy_q | (req & (is_mul | is_div)));
  end

  // Next-state: accept in idle, count down while busy, commit on the last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (is_mul) begin
            state_d   = StMul;
            cnt_d     = MUL_CYCLES[CntW-1:0];
            busy_d    = 1'b1;
            pend_hi_d = ar_hi;
            pend_lo_d = ar_lo;
            pend_wr_d = ar_wr;
`ifdef MDU_DIV_EN
          end else if (is_div) begin
            state_d   = StDiv;
            cnt_d     = DIV_CYCLES[CntW-1:0];
            busy_d    = 1'b1;
            pend_hi_d = ar_hi;
            pend_lo_d = ar_lo;
            pend_wr_d = ar_wr;
`endif
          end else if (op == OpMthi) begin
            hi_d = a;
          end else if (op == OpMtlo) begin
            lo_d = a;
          end
        end
      end
`ifdef MDU_DIV_EN
      StMul, StDiv: begin
`else
      StMul: begin
`endif
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation without committing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy length of MULT/MULTU in cycles (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy length of DIV/DIVU in cycles (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage MD instruction valid this cycle.
REQ-006 SHALL have port op  input  3  operation code (mdu_pkg encoding).
REQ-007 SHALL have port a  input  32  rs operand.
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port flush  input  1  exception/interrupt kill of the current E-stage instruction.
REQ-010 SHALL have port md_use  input  1  E-stage instruction reads or writes HI/LO (MF*/MT*/MULT*/DIV*).
REQ-011 SHALL have port busy  output  1  registered; operation in progress.
REQ-012 SHALL have port md_stall  output  1  combinational stall request to the pipeline.
REQ-013 SHALL have port hi  output  32  architectural HI.
REQ-014 SHALL have port lo  output  32  architectural LO.

Function
REQ-015 SHALL accept start only when start=1, flush=0, op!=NONE and state=IDLE; all other starts are ignored with no state change.
REQ-016 SHALL implement states IDLE, MUL, DIV; accepted MULT/MULTU -> MUL with cnt=MUL_CYCLES; accepted DIV/DIVU -> DIV with cnt=DIV_CYCLES.
REQ-017 SHALL compute the result from a/b at the accepting edge into pending registers; later changes of a/b have no effect.
REQ-018 SHALL decrement cnt each cycle in MUL/DIV; on the edge where cnt=1, write pending HI/LO to hi/lo and return to IDLE.
REQ-019 SHALL drive busy=1 for exactly MUL_CYCLES (or DIV_CYCLES) cycles starting the cycle after the accepting edge; new hi/lo visible the first cycle busy=0.
REQ-020 SHALL produce MULT: {hi,lo}=signed 64-bit product; MULTU: unsigned product; DIV: lo=signed quotient, hi=signed remainder (truncate toward zero, remainder sign = dividend sign); DIVU: unsigned.
REQ-021 SHALL leave hi and lo unchanged on DIV/DIVU with b=0 (busy sequence still runs); DIV 0x80000000/0xFFFFFFFF yields lo=0x80000000, hi=0.
REQ-022 SHALL execute accepted MTHI (hi<=a) / MTLO (lo<=a) at the accepting edge with no busy cycles.
REQ-023 SHALL drive md_stall = md_use & (busy | (start & ~flush & op in {MULT,MULTU,DIV,DIVU})) — first-cycle stall covers a back-to-back MD consumer.
REQ-024 SHALL let flush asserted while busy=1 have no effect; the in-flight operation commits normally.

Reset
REQ-025 SHALL on reset asynchronously force state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending registers=0, aborting any in-flight operation with no commit.
REQ-026 SHALL accept a new start on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL compile divide support only when macro MDU_DIV_EN is defined; without it DIV/DIVU are treated as op=NONE (ignored, no busy, md_stall from them =0), state DIV and divider logic absent.

Structure
REQ-028 SHALL place op encoding (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), state enum and cnt width constant in package mdu_pkg.
REQ-029 SHALL isolate the combinational 64-bit multiply/divide result generation in sub-module mdu_arith; mdu_ctrl holds FSM, counter and HI/LO.

Verification
REQ-030 SHALL verify MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 SHALL verify DIV a=-7, b=2 (MDU_DIV_EN) -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-032 SHALL verify start MULTU with flush=1 -> busy stays 0, hi/lo unchanged, md_stall=md_use&0=0.
REQ-033 SHALL verify MULTU 0xFFFFFFFF*0xFFFFFFFF followed next cycle by md_use=1, start=1 (MFLO) -> md_stall=1 on the issue cycle and 5 busy cycles, MFLO start ignored while busy, lo=0x00000001, hi=0xFFFFFFFE.
REQ-034 SHALL verify reset asserted at busy cycle 3 of MULT 5*6 -> immediate busy=0, hi=lo=0, no later commit of 30.
REQ-035 SHALL verify MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never asserted; without MDU_DIV_EN, DIV start -> busy=0, hi/lo unchanged.
